// File: rtl/async_proc_pkg.sv
// Shared types and constants for the asynchronous-processor program loader.
//   state_e : loader FSM states
//   WORD_W  : program word width
//   BYTE_W  : host byte width
package async_proc_pkg;

  localparam int WORD_W = 16;
  localparam int BYTE_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    LO,
    LO_REL,
    HI,
    HI_REL,
    WR_REQ,
    WR_REL,
    RUN
  } state_e;

endpackage

// File: rtl/async_proc_sync.sv
// N-flop level synchroniser bringing an asynchronous signal into clk.
//   clk   : destination clock
//   rst_n : asynchronous active-low reset, clears every stage
//   d     : asynchronous input
//   q     : synchronised output (last stage)
module async_proc_sync #(
  parameter int N = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [N-1:0] sync_q;
  logic [N-1:0] sync_d;

  assign sync_d = {sync_q[N-2:0], d};

  // NOTE: sequential state uses non-blocking assignments so every stage
  // samples the previous stage's old value on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= sync_d;
  end

  assign q = sync_q[N-1];

endmodule

// File: rtl/async_proc_prog_loader.sv
// Host-facing program loader for the asynchronous processor core.
// Assembles little-endian byte pairs from a 4-phase host handshake into
// 16-bit words, writes them into program memory over a 4-phase
// bundled-data handshake, then releases the core.
//   clk, rst_n            : clock, asynchronous active-low reset
//   ena                   : design selected; gates host_stb
//   host_load             : async, 1 = load mode, 0 = run
//   host_stb/host_data    : async host request and byte
//   host_ack              : registered acknowledge to the host
//   mem_req/mem_addr/
//   mem_wdata             : registered write request bundle to core memory
//   mem_ack               : async acknowledge from core memory
//   core_run              : releases the core
//   word_count            : words written since load start
//   err                   : sticky error (overflow or partial word)
module async_proc_prog_loader
  import async_proc_pkg::*;
#(
  parameter int ADDR_W      = 5,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ena,
  input  logic                host_load,
  input  logic                host_stb,
  input  logic [BYTE_W-1:0]   host_data,
  output logic                host_ack,
  output logic                mem_req,
  input  logic                mem_ack,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [WORD_W-1:0]   mem_wdata,
  output logic                core_run,
  output logic [ADDR_W:0]     word_count,
  output logic                err
);

  localparam logic [ADDR_W:0]   DEPTH    = (ADDR_W+1)'(2**ADDR_W);
  localparam logic [ADDR_W-1:0] ADDR_MAX = {ADDR_W{1'b1}};

  logic s_load, s_stb, s_ack;

  // ena is gated before synchronisation so a deselected host looks idle.
  async_proc_sync #(.N(SYNC_STAGES)) u_sync_load (
    .clk(clk), .rst_n(rst_n), .d(host_load), .q(s_load));
  async_proc_sync #(.N(SYNC_STAGES)) u_sync_stb (
    .clk(clk), .rst_n(rst_n), .d(host_stb & ena), .q(s_stb));
  async_proc_sync #(.N(SYNC_STAGES)) u_sync_ack (
    .clk(clk), .rst_n(rst_n), .d(mem_ack), .q(s_ack));

  state_e              state_q, state_d;
  logic [BYTE_W-1:0]   lo_q, lo_d, hi_q, hi_d;
  logic                host_ack_q, host_ack_d;
  logic                mem_req_q, mem_req_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W:0]     word_count_q, word_count_d;
  logic                core_run_q, core_run_d;
  logic                err_q, err_d;

  // NOTE: every variable gets its hold value first so no path through the
  // case statement leaves one unassigned and infers a latch.
  always_comb begin
    state_d      = state_q;
    lo_d         = lo_q;
    hi_d         = hi_q;
    host_ack_d   = host_ack_q;
    mem_req_d    = mem_req_q;
    addr_d       = addr_q;
    word_count_d = word_count_q;
    core_run_d   = core_run_q;
    err_d        = err_q;

    unique case (state_q)
      IDLE: if (s_load) state_d = LO;

      // Leaving load mode has priority over a new byte.
      LO: begin
        if (!s_load) begin
          core_run_d = 1'b1;
          state_d    = RUN;
        end else if (s_stb) begin
          lo_d       = host_data;
          host_ack_d = 1'b1;
          state_d    = LO_REL;
        end
      end

      LO_REL: if (!s_stb) begin
        host_ack_d = 1'b0;
        state_d    = HI;
      end

      HI: begin
        if (!s_load) begin
          // Half a word is pending: discard it and flag the host.
          err_d      = 1'b1;
          core_run_d = 1'b1;
          state_d    = RUN;
        end else if (s_stb) begin
          hi_d       = host_data;
          host_ack_d = 1'b1;
          if (word_count_q < DEPTH) begin
            // Request rises on the same edge as the data/address settle,
            // so the bundle is stable for the whole request.
            mem_req_d = 1'b1;
            state_d   = WR_REQ;
          end else begin
            err_d   = 1'b1;
            state_d = HI_REL;
          end
        end
      end

      WR_REQ: if (s_ack) begin
        mem_req_d = 1'b0;
        state_d   = WR_REL;
      end

      // host_ack remains high through the memory handshake to back-pressure
      // the host; it is released from HI_REL.
      WR_REL: if (!s_ack) begin
        word_count_d = word_count_q + (ADDR_W+1)'(1);
        if (addr_q != ADDR_MAX) addr_d = addr_q + ADDR_W'(1);
        state_d = HI_REL;
      end

      HI_REL: if (!s_stb) begin
        host_ack_d = 1'b0;
        state_d    = LO;
      end

      RUN: if (s_load) begin
        core_run_d   = 1'b0;
        err_d        = 1'b0;
        word_count_d = '0;
        addr_d       = '0;
        state_d      = LO;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      lo_q         <= '0;
      hi_q         <= '0;
      host_ack_q   <= 1'b0;
      mem_req_q    <= 1'b0;
      addr_q       <= '0;
      word_count_q <= '0;
      core_run_q   <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      lo_q         <= lo_d;
      hi_q         <= hi_d;
      host_ack_q   <= host_ack_d;
      mem_req_q    <= mem_req_d;
      addr_q       <= addr_d;
      word_count_q <= word_count_d;
      core_run_q   <= core_run_d;
      err_q        <= err_d;
    end
  end

  assign host_ack   = host_ack_q;
  assign mem_req    = mem_req_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = {hi_q, lo_q};
  assign core_run   = core_run_q;
  assign word_count = word_count_q;
  assign err        = err_q;

endmodule

// File: tb/tb_async_proc_prog_loader.sv
// Self-checking bench for async_proc_prog_loader (ADDR_W=5, SYNC_STAGES=2).
// A host driver, a memory responder, a transaction-level model of the
// expected memory writes and status, and one per-cycle compare process.
module tb_async_proc_prog_loader;

  localparam int ADDR_W = 5;
  localparam int DEPTH  = 32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ena = 1'b1;
  logic        host_load = 1'b0;
  logic        host_stb = 1'b0;
  logic [7:0]  host_data = 8'h00;
  logic        host_ack;
  logic        mem_req;
  logic        mem_ack = 1'b0;
  logic [4:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic        core_run;
  logic [5:0]  word_count;
  logic        err;

  always #5 clk = ~clk;

  async_proc_prog_loader #(.ADDR_W(ADDR_W), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .host_load(host_load), .host_stb(host_stb), .host_data(host_data),
    .host_ack(host_ack), .mem_req(mem_req), .mem_ack(mem_ack),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .core_run(core_run),
    .word_count(word_count), .err(err)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  typedef struct { logic [4:0] addr; logic [15:0] data; } wr_t;
  wr_t exp_q[$];
  int  m_wc = 0;
  int  m_addr = 0;
  bit  m_err = 0;
  bit  m_run = 0;

  task automatic model_clear();
    exp_q.delete();
    m_wc = 0; m_addr = 0; m_err = 0; m_run = 0;
  endtask

  // A complete word: written if there is room, otherwise dropped with error.
  task automatic model_word(input logic [7:0] lo, input logic [7:0] hi);
    wr_t w;
    if (m_wc < DEPTH) begin
      w.addr = 5'(m_addr);
      w.data = {hi, lo};
      exp_q.push_back(w);
      m_wc++;
      if (m_addr < DEPTH-1) m_addr++;
    end else begin
      m_err = 1;
    end
  endtask

  // ---------------- memory responder ----------------
  int          mem_delay = 0;
  logic [15:0] mem_arr [DEPTH];
  logic [4:0]  last_addr = '0;
  logic [15:0] last_data = '0;

  initial begin
    for (int i = 0; i < DEPTH; i++) mem_arr[i] = 16'h0000;
    forever begin
      @(negedge clk);
      if (rst_n && mem_req && !mem_ack) begin
        repeat (mem_delay) @(negedge clk);
        mem_arr[mem_addr] = mem_wdata;
        last_addr = mem_addr;
        last_data = mem_wdata;
        mem_ack = 1'b1;
        for (int n = 0; n < 200 && mem_req; n++) @(negedge clk);
        check("mem_req_drop", 32'(mem_req), 32'd0);
        mem_ack = 1'b0;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  logic        req_prev = 1'b0;
  logic [4:0]  hold_addr = '0;
  logic [15:0] hold_data = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      req_prev = 1'b0;
    end else begin
      if (mem_req && !req_prev) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write", 32'(mem_req), 32'd0);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          check("wr_addr", 32'(mem_addr), 32'(e.addr));
          check("wr_data", 32'(mem_wdata), 32'(e.data));
        end
        hold_addr = mem_addr;
        hold_data = mem_wdata;
      end else if (mem_req) begin
        check("wr_stable", {11'd0, mem_addr, mem_wdata}, {11'd0, hold_addr, hold_data});
      end
      if (mem_req) check("ack_held_during_write", 32'(host_ack), 32'd1);
      if (core_run) check("run_quiet", {30'd0, host_ack, mem_req}, 32'd0);
      req_prev = mem_req;
    end
  end

  // ---------------- host driver ----------------
  // Called at a negedge; counts rising edges until the ack edge is visible.
  task automatic send_byte(input logic [7:0] b, output int rise_lat, output int fall_lat);
    host_data = b;
    host_stb  = 1'b1;
    rise_lat  = 0;
    do begin @(posedge clk); rise_lat++; @(negedge clk); end
    while (!host_ack && rise_lat < 400);
    check("ack_rise", 32'(host_ack), 32'd1);
    host_stb = 1'b0;
    fall_lat = 0;
    do begin @(posedge clk); fall_lat++; @(negedge clk); end
    while (host_ack && fall_lat < 400);
    check("ack_fall", 32'(host_ack), 32'd0);
  endtask

  task automatic finish_word(input logic [7:0] lo, input logic [7:0] hi, output int hi_fall);
    int r;
    model_word(lo, hi);
    send_byte(hi, r, hi_fall);
    check("word_count", 32'(word_count), 32'(m_wc));
  endtask

  task automatic send_word(input logic [7:0] lo, input logic [7:0] hi,
                           output int lo_rise, output int lo_fall, output int hi_fall);
    send_byte(lo, lo_rise, lo_fall);
    finish_word(lo, hi, hi_fall);
  endtask

  task automatic check_status(input string name);
    check({name, "_core_run"}, 32'(core_run), 32'(m_run));
    check({name, "_word_count"}, 32'(word_count), 32'(m_wc));
    check({name, "_err"}, 32'(err), 32'(m_err));
  endtask

  task automatic check_all_zero(input string name);
    check(name, {host_ack, mem_req, mem_addr, mem_wdata, core_run, word_count, err},
          32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int rl, fl, hf, lat;

    // Power-on reset.
    repeat (3) @(negedge clk);
    check_all_zero("reset_outputs");
    rst_n = 1'b1;
    @(negedge clk);

    // Reset in the middle of a load, while the low byte is acked.
    host_load = 1'b1;
    repeat (5) @(negedge clk);
    host_data = 8'h34;
    host_stb  = 1'b1;
    for (int n = 0; n < 20 && !host_ack; n++) @(negedge clk);
    check("pre_reset_ack", 32'(host_ack), 32'd1);
    rst_n = 1'b0;
    #1;
    check_all_zero("async_reset_outputs");
    host_stb  = 1'b0;
    host_load = 1'b0;
    model_clear();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check_all_zero("idle_after_reset");

    // Basic word 0x1234 with immediate memory ack.
    host_load = 1'b1;
    repeat (5) @(negedge clk);
    mem_delay = 0;
    send_word(8'h34, 8'h12, rl, fl, hf);
    check("ack_rise_latency", 32'(rl), 32'd3);
    check("ack_fall_latency", 32'(fl), 32'd3);
    check("first_write_addr", 32'(last_addr), 32'd0);
    check("first_write_data", 32'(last_data), 32'h1234);
    host_load = 1'b0;
    m_run = 1;
    repeat (6) @(negedge clk);
    check_status("run1");
    check("run1_literal", {29'd0, core_run, word_count == 6'd1, err}, 32'b110);

    // Re-enter load mode from RUN.
    host_load = 1'b1;
    m_run = 0; m_err = 0; m_wc = 0; m_addr = 0;
    repeat (6) @(negedge clk);
    check_status("reload1");

    // Memory stalls its ack for 20 cycles: host stays back-pressured.
    mem_delay = 20;
    send_word(8'hCD, 8'hAB, rl, fl, hf);
    check("backpressure_hi_ack", 32'(hf >= 20), 32'd1);
    mem_delay = 1;

    // Load dropped after the low byte only.
    send_byte(8'h55, rl, fl);
    host_load = 1'b0;
    m_run = 1; m_err = 1;
    repeat (6) @(negedge clk);
    check_status("partial");
    check("partial_err_literal", 32'(err), 32'd1);

    host_load = 1'b1;
    m_run = 0; m_err = 0; m_wc = 0; m_addr = 0;
    repeat (6) @(negedge clk);
    check_status("reload2");
    check("reload2_literal", {26'd0, word_count}, 32'd0);

    // ena low while host_stb is high: no ack until ena returns.
    ena       = 1'b0;
    host_data = 8'h77;
    host_stb  = 1'b1;
    repeat (10) @(negedge clk);
    check("ena_low_no_ack", 32'(host_ack), 32'd0);
    ena = 1'b1;
    lat = 0;
    do begin @(posedge clk); lat++; @(negedge clk); end
    while (!host_ack && lat < 400);
    check("ena_ack_latency", 32'(lat), 32'd3);
    host_stb = 1'b0;
    for (int n = 0; n < 20 && host_ack; n++) @(negedge clk);
    check("ena_ack_fall", 32'(host_ack), 32'd0);
    finish_word(8'h77, 8'h66, hf);
    check("ena_word_data", 32'(mem_arr[0]), 32'h6677);

    // Fill: 32 more words, the last one overflows the 32-word memory.
    for (int k = 1; k <= 32; k++) begin
      logic [7:0] kb;
      kb = 8'(k);
      send_word(kb, kb ^ 8'hA5, rl, fl, hf);
    end
    check("full_word_count", {26'd0, word_count}, 32'd32);
    check("full_err", 32'(err), 32'd1);
    check("full_last_addr", 32'(last_addr), 32'd31);
    check("full_mem31", 32'(mem_arr[31]), 32'hBA1F);
    check("full_mem1", 32'(mem_arr[1]), 32'hA401);
    host_load = 1'b0;
    m_run = 1;
    repeat (6) @(negedge clk);
    check_status("run_full");
    check("pending_writes", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
